// File: rtl/tick_gen_pkg.sv
// ---------------------------------------------------------------------------
// tick_gen_pkg
// Shared types for the programmable tick/clock-divider bank.
//   mode_t : per-channel operating mode (2-bit encoding on the mode bus)
//   MODE_W : width of one channel's mode slice
// ---------------------------------------------------------------------------
package tick_gen_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_PERIODIC = 2'b00,
      MODE_SQUARE   = 2'b01,
      MODE_ONESHOT  = 2'b10,
      MODE_RSVD     = 2'b11
   } mode_t;

endpackage

// File: rtl/tick_chan.sv
// ---------------------------------------------------------------------------
// tick_chan
// One divider channel: counter, double-buffered limit (shadow -> act_lim),
// square-wave toggle and one-shot busy flag.
//   clk, n_rst : clock, asynchronous active-low reset
//   en         : 0 freezes counter/sq/busy and forces tick low
//   clear      : synchronous clear of counter/tick/sq/busy; commits shadow
//   mode       : MODE_PERIODIC / MODE_SQUARE / MODE_ONESHOT / MODE_RSVD
//   lim        : new limit value, captured into shadow by lim_load
//   lim_load   : capture strobe for lim
//   start      : one-shot trigger (ignored while busy or disabled)
//   tick       : registered one-cycle terminal pulse
//   sq         : square output, toggles on each terminal count in SQUARE
//   busy       : one-shot in progress
//   counter    : current count
// ---------------------------------------------------------------------------
module tick_chan
   import tick_gen_pkg::*;
#(
   parameter int               WIDTH   = 23,
   parameter logic [WIDTH-1:0] RST_LIM = '0
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              en,
   input  logic              clear,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  lim,
   input  logic              lim_load,
   input  logic              start,
   output logic              tick,
   output logic              sq,
   output logic              busy,
   output logic [WIDTH-1:0]  counter
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] act_lim;
   logic [WIDTH-1:0] shadow;
   logic             term;
   logic             commit;
   mode_t            md;

   // Saturating increment: the counter can never wrap past all-ones.
   function automatic logic [WIDTH-1:0] inc_sat(input logic [WIDTH-1:0] v);
      return (v == '1) ? v : v + ONE;
   endfunction

   assign md = mode_t'(mode);

   // >= rather than == so a limit lowered below the running count
   // terminates immediately instead of running away to the wrap point.
   assign term   = (counter >= act_lim);
   assign commit = term | clear | ~en;

   // Limit double buffer: a same-cycle load and commit bypasses the shadow.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         shadow  <= RST_LIM;
         act_lim <= RST_LIM;
      end else begin
         if (lim_load)
            shadow <= lim;
         if (commit)
            act_lim <= lim_load ? lim : shadow;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         counter <= '0;
         tick    <= 1'b0;
         sq      <= 1'b0;
         busy    <= 1'b0;
      end else if (clear) begin
         counter <= '0;
         tick    <= 1'b0;
         sq      <= 1'b0;
         busy    <= 1'b0;
      end else if (!en) begin
         tick <= 1'b0;
      end else begin
         case (md)
            MODE_PERIODIC, MODE_SQUARE: begin
               busy <= 1'b0;
               if (term) begin
                  counter <= '0;
                  tick    <= 1'b1;
                  if (md == MODE_SQUARE)
                     sq <= ~sq;
               end else begin
                  counter <= inc_sat(counter);
                  tick    <= 1'b0;
               end
            end
            MODE_ONESHOT: begin
               if (busy) begin
                  // start is deliberately not looked at here, so a retrigger
                  // during the shot (even in its terminal cycle) is dropped.
                  if (term) begin
                     counter <= '0;
                     tick    <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     counter <= inc_sat(counter);
                     tick    <= 1'b0;
                  end
               end else begin
                  tick <= 1'b0;
                  if (start) begin
                     busy    <= 1'b1;
                     counter <= '0;
                  end
               end
            end
            default: begin
               tick <= 1'b0;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tick_gen_multi
// Bank of CH independent programmable tick/clock-divider channels used by the
// note scheduler, beat LEDs and tone generator. This level only slices the
// flattened per-channel buses; all behaviour lives in tick_chan.
//   clk, n_rst : clock, asynchronous active-low reset
//   en[CH]              : per-channel enable
//   clear[CH]           : per-channel synchronous clear
//   mode[2*CH]          : channel i uses mode[2i+1:2i]
//   lim[WIDTH*CH]       : channel i uses lim[WIDTH*(i+1)-1:WIDTH*i]
//   lim_load[CH]        : capture lim slice into the channel shadow
//   start[CH]           : one-shot trigger
//   tick[CH]            : one-cycle terminal pulse
//   sq[CH]              : square output
//   busy[CH]            : one-shot in progress
//   counter[WIDTH*CH]   : per-channel current count
// ---------------------------------------------------------------------------
module tick_gen_multi
   import tick_gen_pkg::*;
#(
   parameter int               CH      = 4,
   parameter int               WIDTH   = 23,
   parameter logic [WIDTH-1:0] RST_LIM = '0
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic [CH-1:0]         en,
   input  logic [CH-1:0]         clear,
   input  logic [MODE_W*CH-1:0]  mode,
   input  logic [WIDTH*CH-1:0]   lim,
   input  logic [CH-1:0]         lim_load,
   input  logic [CH-1:0]         start,
   output logic [CH-1:0]         tick,
   output logic [CH-1:0]         sq,
   output logic [CH-1:0]         busy,
   output logic [WIDTH*CH-1:0]   counter
);

   for (genvar i = 0; i < CH; i++) begin : g_chan
      tick_chan #(
         .WIDTH   (WIDTH),
         .RST_LIM (RST_LIM)
      ) u_chan (
         .clk      (clk),
         .n_rst    (n_rst),
         .en       (en[i]),
         .clear    (clear[i]),
         .mode     (mode[MODE_W*i +: MODE_W]),
         .lim      (lim[WIDTH*i +: WIDTH]),
         .lim_load (lim_load[i]),
         .start    (start[i]),
         .tick     (tick[i]),
         .sq       (sq[i]),
         .busy     (busy[i]),
         .counter  (counter[WIDTH*i +: WIDTH])
      );
   end

endmodule
